hazard_stall_unit: RTL and testbench

- Drives stall and flush controls back into the front of the pipeline.
- Consumes the decoded destination and memory-read fields held by the ID/EXE and EXE/MEM boundary registers, and compares them against the source registers of the instruction in ID.
- Generates: PC hold, IF/ID hold, IF/ID flush, and an ID/EXE bubble that zeroes the ID/EXE control inputs.
- Sequences multi-cycle stalls with a small FSM and keeps saturating stall/flush statistics counters.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_stall_unit_sat_counter.sv | 30 +++
 rtl/hazard_stall_unit.sv | 149 ++++++++++++++
 tb/tb_hazard_stall_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall control slice.
package hazard_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    HZ_RUN  = 1'b0,
    HZ_HOLD = 1'b1
  } hz_state_t;

  // A producer destination conflicts with the ID instruction's sources; $0 never conflicts.
  function automatic logic reg_match(input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic             uses_rt);
    reg_match = (dst != ZERO_REG) && ((dst == rs) || (uses_rt && (dst == rt)));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter
  import hazard_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  // Count register: clear, saturating increment, or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= {W{1'b0}};
    end else if (clr) begin
      count <= {W{1'b0}};
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / branch-operand hazard detection driving PC hold, IF/ID hold/flush
// and ID/EXE bubble, with a RUN/HOLD sequencer for the two-cycle branch-on-load case.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             branch_taken,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             mem_ready,
  input  logic             stat_clear,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_exe_bubble,
  output logic             global_stall,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  hz_state_t state_r;
  hz_state_t state_next_s;
  logic      stall_left_r;
  logic      stall_left_next_s;

  logic ex_match_s;
  logic mem_match_s;
  logic lu_s;
  logic ba_s;
  logic bl2_s;
  logic bl1_s;
  logic freeze_s;
  logic stall_s;
  logic stall_inc_s;
  logic clr_s;

  // Hazard classification against the EXE and MEM producers.
  always_comb begin
    ex_match_s  = reg_match(ex_dst, id_rs, id_rt, id_uses_rt);
    mem_match_s = reg_match(mem_dst, id_rs, id_rt, id_uses_rt);
    lu_s        = ex_mem_read && ex_match_s;
    ba_s        = id_branch && ex_reg_write && !ex_mem_read && ex_match_s;
    bl2_s       = id_branch && ex_mem_read && ex_match_s;
    bl1_s       = id_branch && mem_mem_read && mem_match_s;
    freeze_s    = !mem_ready;
    stall_s     = (state_r == HZ_HOLD) || lu_s || ba_s || bl2_s || bl1_s;
  end

  // Next-state logic; a frozen pipeline keeps the sequencer exactly where it is.
  always_comb begin
    state_next_s      = state_r;
    stall_left_next_s = stall_left_r;
    if (freeze_s) begin
      state_next_s      = state_r;
      stall_left_next_s = stall_left_r;
    end else begin
      case (state_r)
        HZ_RUN: begin
          if (bl2_s) begin
            state_next_s      = HZ_HOLD;
            stall_left_next_s = 1'b0;
          end else begin
            state_next_s      = HZ_RUN;
          end
        end
        HZ_HOLD: begin
          if (stall_left_r == 1'b0) begin
            state_next_s      = HZ_RUN;
          end else begin
            state_next_s      = HZ_HOLD;
            stall_left_next_s = stall_left_r - 1'b1;
          end
        end
        default: begin
          state_next_s      = HZ_RUN;
          stall_left_next_s = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= HZ_RUN;
      stall_left_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      stall_left_r <= stall_left_next_s;
    end
  end

  // Pipeline control outputs: reset, then freeze, then stall, then flush/normal.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_bubble = 1'b0;
    global_stall  = 1'b0;
    if (rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_exe_bubble = 1'b1;
    end else if (freeze_s) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      global_stall  = 1'b1;
    end else if (stall_s) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_exe_bubble = 1'b1;
    end else begin
      if_id_flush   = branch_taken;
    end
  end

  // Counter controls; a frozen cycle neither counts nor clears.
  always_comb begin
    stall_inc_s = stall_s && !freeze_s;
    clr_s       = stat_clear && !freeze_s;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_s),
    .inc   (stall_inc_s),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_s),
    .inc   (if_id_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench: constant vector table, directed multi-cycle sequences,
// and randomized stimulus against a pending-stall/count reference model.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
  logic       id_uses_rt, id_branch, branch_taken, ex_mem_read, ex_reg_write;
  logic       mem_mem_read, mem_ready, stat_clear;

  logic        pc_write, if_id_write, if_id_flush, id_exe_bubble, global_stall;
  logic [15:0] stall_cycles, flush_count;
  logic        b_pc_write, b_if_id_write, b_if_id_flush, b_id_exe_bubble, b_global_stall;
  logic [1:0]  b_stall_cycles, b_flush_count;

  int checks = 0;
  int errors = 0;
  int pending;
  int m_stalls;
  int m_flushes;

  always #5 clk = ~clk;

  hazard_stall_unit dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .branch_taken(branch_taken), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_dst(ex_dst), .mem_mem_read(mem_mem_read),
    .mem_dst(mem_dst), .mem_ready(mem_ready), .stat_clear(stat_clear),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_exe_bubble(id_exe_bubble), .global_stall(global_stall),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  hazard_stall_unit #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .branch_taken(branch_taken), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_dst(ex_dst), .mem_mem_read(mem_mem_read),
    .mem_dst(mem_dst), .mem_ready(mem_ready), .stat_clear(stat_clear),
    .pc_write(b_pc_write), .if_id_write(b_if_id_write), .if_id_flush(b_if_id_flush),
    .id_exe_bubble(b_id_exe_bubble), .global_stall(b_global_stall),
    .stall_cycles(b_stall_cycles), .flush_count(b_flush_count)
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       branch;
    logic       taken;
    logic       ex_mr;
    logic       ex_rw;
    logic [4:0] ex_d;
    logic       mem_mr;
    logic [4:0] mem_d;
    logic [4:0] exp;   // {pc_write, if_id_write, if_id_flush, id_exe_bubble, global_stall}
  } vec_t;

  vec_t tbl[12];

  localparam logic [4:0] O_STALL  = 5'b00010;
  localparam logic [4:0] O_NORM   = 5'b11000;
  localparam logic [4:0] O_FLUSH  = 5'b11100;
  localparam logic [4:0] O_FREEZE = 5'b00001;
  localparam logic [4:0] O_RESET  = 5'b00010;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic bit hit(input logic [4:0] d);
    return (d != 5'd0) && ((d == id_rs) || (id_uses_rt && (d == id_rt)));
  endfunction

  function automatic bit needs_two();
    return id_branch && ex_mem_read && hit(ex_dst);
  endfunction

  function automatic bit any_hazard();
    return (ex_mem_read && hit(ex_dst)) ||
           (id_branch && ex_reg_write && !ex_mem_read && hit(ex_dst)) ||
           needs_two() ||
           (id_branch && mem_mem_read && hit(mem_dst));
  endfunction

  function automatic logic [4:0] model_out();
    if (rst) return O_RESET;
    if (!mem_ready) return O_FREEZE;
    if ((pending > 0) || any_hazard()) return O_STALL;
    return {1'b1, 1'b1, branch_taken, 1'b0, 1'b0};
  endfunction

  task automatic model_reset();
    pending = 0;
    m_stalls = 0;
    m_flushes = 0;
  endtask

  task automatic model_update();
    bit stall, flush;
    if (rst) begin
      model_reset();
    end else if (mem_ready) begin
      stall = (pending > 0) || any_hazard();
      flush = branch_taken && !stall;
      if (stat_clear) begin
        m_stalls = 0;
        m_flushes = 0;
      end else begin
        m_stalls += int'(stall);
        m_flushes += int'(flush);
      end
      if (pending > 0) pending--;
      else if (needs_two()) pending = 1;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cmp_counts(input string name);
    cmp({name, ".stall_cycles"}, 32'(stall_cycles), sat(m_stalls, 65535));
    cmp({name, ".flush_count"}, 32'(flush_count), sat(m_flushes, 65535));
    cmp({name, ".stall_cycles_w2"}, 32'(b_stall_cycles), sat(m_stalls, 3));
    cmp({name, ".flush_count_w2"}, 32'(b_flush_count), sat(m_flushes, 3));
  endtask

  task automatic tick(input string name, input logic [4:0] exp);
    @(negedge clk);
    cmp({name, ".ctrl"}, 32'({pc_write, if_id_write, if_id_flush, id_exe_bubble, global_stall}), 32'(exp));
    cmp({name, ".ctrl_w2"}, 32'({b_pc_write, b_if_id_write, b_if_id_flush, b_id_exe_bubble, b_global_stall}), 32'(exp));
    cmp_counts(name);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_branch = 1'b0; branch_taken = 1'b0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dst = 5'd0;
    mem_mem_read = 1'b0; mem_dst = 5'd0; mem_ready = 1'b1; stat_clear = 1'b0;
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    model_reset();
    tick(name, O_RESET);
    rst = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt; id_branch = v.branch;
    branch_taken = v.taken; ex_mem_read = v.ex_mr; ex_reg_write = v.ex_rw; ex_dst = v.ex_d;
    mem_mem_read = v.mem_mr; mem_dst = v.mem_d; mem_ready = 1'b1; stat_clear = 1'b0;
  endtask

  task automatic set_bl2();
    idle();
    id_branch = 1'b1; ex_mem_read = 1'b1; ex_dst = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
  endtask

  initial begin
    //            rs    rt    urt   br    tk    exmr  exrw  exd   mmr   md    expected
    tbl[0]  = '{5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, O_STALL};
    tbl[1]  = '{5'd1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, O_STALL};
    tbl[2]  = '{5'd1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, O_NORM};
    tbl[3]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, O_NORM};
    tbl[4]  = '{5'd6, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0, 5'd0, O_STALL};
    tbl[5]  = '{5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0, 5'd0, O_NORM};
    tbl[6]  = '{5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, O_STALL};
    tbl[7]  = '{5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, O_NORM};
    tbl[8]  = '{5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, O_FLUSH};
    tbl[9]  = '{5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 5'd0, O_STALL};
    tbl[10] = '{5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, O_NORM};
    tbl[11] = '{5'd6, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 1'b0, 5'd0, O_NORM};

    idle();
    do_reset("reset");

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i]);
      tick($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Load-use: one stall, then the bubble reaches EXE.
    do_reset("lu_reset");
    idle(); ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd3; id_rs = 5'd3;
    tick("lu_stall", O_STALL);
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dst = 5'd0;
    tick("lu_release", O_NORM);
    cmp("lu_count", 32'(stall_cycles), 32'd1);

    // Branch on a load in EXE: two stalls, then the taken branch flushes.
    do_reset("bl2_reset");
    set_bl2();
    tick("bl2_c1", O_STALL);
    ex_mem_read = 1'b0; ex_dst = 5'd0; mem_mem_read = 1'b1; mem_dst = 5'd5;
    tick("bl2_c2", O_STALL);
    mem_mem_read = 1'b0; mem_dst = 5'd0; branch_taken = 1'b1;
    tick("bl2_flush", O_FLUSH);
    idle();
    tick("bl2_after", O_NORM);
    cmp("bl2_flush_count", 32'(flush_count), 32'd1);
    cmp("bl2_stall_count", 32'(stall_cycles), 32'd2);

    // Freeze while holding: everything waits, then the held stall completes.
    do_reset("frz_reset");
    set_bl2();
    tick("frz_enter", O_STALL);
    idle(); mem_ready = 1'b0; branch_taken = 1'b1; ex_mem_read = 1'b1; ex_dst = 5'd2; id_rs = 5'd2;
    for (int i = 0; i < 3; i++) tick($sformatf("frz%0d", i), O_FREEZE);
    idle();
    tick("frz_hold", O_STALL);
    tick("frz_run", O_NORM);
    cmp("frz_stall_count", 32'(stall_cycles), 32'd2);

    // Saturation of the narrow counter, then clear during a stall.
    do_reset("sat_reset");
    idle(); ex_mem_read = 1'b1; ex_dst = 5'd9; id_rs = 5'd9;
    for (int i = 0; i < 5; i++) tick($sformatf("sat%0d", i), O_STALL);
    cmp("sat_w2", 32'(b_stall_cycles), 32'd3);
    cmp("sat_w16", 32'(stall_cycles), 32'd5);
    stat_clear = 1'b1;
    tick("clr_stall", O_STALL);
    idle();
    cmp("clr_w2", 32'(b_stall_cycles), 32'd0);
    cmp("clr_w16", 32'(stall_cycles), 32'd0);

    // Asynchronous reset in the middle of HOLD.
    do_reset("ar_reset");
    set_bl2();
    tick("ar_enter", O_STALL);
    idle();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    cmp("ar_ctrl", 32'({pc_write, if_id_write, if_id_flush, id_exe_bubble, global_stall}), 32'(O_RESET));
    cmp("ar_count", 32'(stall_cycles), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick("ar_post", O_NORM);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      id_rs        = 5'($urandom_range(0, 7));
      id_rt        = 5'($urandom_range(0, 7));
      id_uses_rt   = 1'($urandom_range(0, 1));
      id_branch    = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      ex_mem_read  = ($urandom_range(0, 2) == 0);
      ex_reg_write = 1'($urandom_range(0, 1));
      ex_dst       = 5'($urandom_range(0, 7));
      mem_mem_read = ($urandom_range(0, 2) == 0);
      mem_dst      = 5'($urandom_range(0, 7));
      mem_ready    = ($urandom_range(0, 9) != 0);
      stat_clear   = mem_ready && ($urandom_range(0, 39) == 0);
      tick("rand", model_out());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
